// File: rtl/alu_unit.sv
// alu_unit -- 16-bit integer ALU for the execute stage.
//
// The result and status path is purely combinational. The only state is a
// 4-bit condition-code register that samples the status flags on a clk
// rising edge when flag_en is high.
//
// Ports:
//   clk       in   rising edge updates cc
//   rst_n     in   async active-low, clears cc
//   op        in   [OPW-1:0]   operation select (12-15 reserved)
//   a, b      in   [WIDTH-1:0] two's complement operands; b[3:0] = shift amount
//   flag_en   in   enables the cc load
//   result    out  [WIDTH-1:0] primary result
//   result_hi out  [WIDTH-1:0] MUL high half / DIV remainder / else 0
//   ovf, zero, neg, dbz, illegal  out  combinational status
//   cc        out  [3:0]       registered {ovf, zero, neg, dbz}
`timescale 1ns/1ps
module alu_unit #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_en,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             dbz,
  output logic             illegal,
  output logic [3:0]       cc
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(4);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(7);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(8);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(9);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(10);
  localparam logic [OPW-1:0] OP_MOVB = OPW'(11);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]          w_sum, w_dif;
  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [WIDTH-1:0]   w_quo, w_rem;
  logic [SHW-1:0]            w_sh;
  logic [SHW:0]              w_sh_inv;
  logic [WIDTH-1:0]          w_sll, w_srl, w_sra, w_rol, w_ror;
  logic                      w_mul_ovf;

  assign w_sum = a + b;
  assign w_dif = a - b;

  // Sign-extend both operands to full product width so the multiply is signed.
  assign w_prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  // Overflow when the upper half is not a sign extension of the lower half.
  assign w_mul_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});

  // Divide-by-zero and MOST_NEG/-1 are handled explicitly below; these
  // values are only used when neither corner case is present.
  assign w_quo = $signed(a) / $signed(b);
  assign w_rem = $signed(a) % $signed(b);

  assign w_sh     = b[SHW-1:0];
  assign w_sll    = a << w_sh;
  assign w_srl    = a >> w_sh;
  assign w_sra    = $signed(a) >>> w_sh;
  // Shift amount 0 gives an inverse shift of WIDTH, which yields 0, so the
  // rotate collapses to a pass-through without a special case.
  assign w_sh_inv = (SHW+1)'(WIDTH) - {1'b0, w_sh};
  assign w_rol    = (a << w_sh) | (a >> w_sh_inv);
  assign w_ror    = (a >> w_sh) | (a << w_sh_inv);

  always_comb begin
    result    = '0;
    result_hi = '0;
    ovf       = 1'b0;
    dbz       = 1'b0;
    illegal   = 1'b0;
    case (op)
      OP_ADD: begin
        result = w_sum;
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = w_dif;
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_MUL: begin
        result    = w_prod[WIDTH-1:0];
        result_hi = w_prod[2*WIDTH-1:WIDTH];
        ovf       = w_mul_ovf;
      end
      OP_DIV: begin
        if (b == '0) begin
          result_hi = a;
          dbz       = 1'b1;
        end else if (a == MOST_NEG && b == '1) begin
          // True quotient +2^(WIDTH-1) is unrepresentable; wraps to MOST_NEG.
          result = MOST_NEG;
          ovf    = 1'b1;
        end else begin
          result    = w_quo;
          result_hi = w_rem;
        end
      end
      OP_SLL:  result = w_sll;
      OP_SRL:  result = w_srl;
      OP_SRA:  result = w_sra;
      OP_ROL:  result = w_rol;
      OP_ROR:  result = w_ror;
      OP_MOVB: result = b;
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[WIDTH-1];

  logic [3:0] r_cc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_cc <= 4'b0000;
    else if (flag_en) r_cc <= {ovf, zero, neg, dbz};
  end

  assign cc = r_cc;

endmodule

// File: tb/tb_alu_unit.sv
`timescale 1ns/1ps
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        flag_en;
  logic [15:0] result, result_hi;
  logic        ovf, zero, neg, dbz, illegal;
  logic [3:0]  cc;

  int n_vec = 0;
  int n_bad = 0;

  alu_unit #(.WIDTH(16), .OPW(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .a(a), .b(b), .flag_en(flag_en),
    .result(result), .result_hi(result_hi), .ovf(ovf), .zero(zero),
    .neg(neg), .dbz(dbz), .illegal(illegal), .cc(cc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic        ovf, zero, neg, dbz, ill;
  } exp_t;

  // Reference model: integer arithmetic on the mathematical values.
  function automatic exp_t model(logic [3:0] o, logic [15:0] va, logic [15:0] vb);
    exp_t e;
    int sa, sb, ua, p, q, s;
    e  = '0;
    sa = int'($signed(va));
    sb = int'($signed(vb));
    ua = int'(va);
    s  = int'(vb[3:0]);
    case (o)
      4'd0: begin p = sa + sb; e.res = p[15:0]; e.ovf = (p > 32767 || p < -32768); end
      4'd1: begin p = sa - sb; e.res = p[15:0]; e.ovf = (p > 32767 || p < -32768); end
      4'd2: e.res = va & vb;
      4'd3: e.res = va | vb;
      4'd4: begin
        p = sa * sb; e.res = p[15:0]; e.hi = p[31:16];
        e.ovf = (p > 32767 || p < -32768);
      end
      4'd5: begin
        if (sb == 0) begin e.hi = va; e.dbz = 1'b1; end
        else begin
          p = sa / sb; q = sa % sb;
          e.res = p[15:0]; e.hi = q[15:0]; e.ovf = (p > 32767);
        end
      end
      4'd6: begin p = ua * (2 ** s); e.res = p[15:0]; end
      4'd7: begin p = ua / (2 ** s); e.res = p[15:0]; end
      4'd8: begin
        p = sa;
        for (int i = 0; i < s; i++) p = (p - (p & 1)) / 2;  // floor halving
        e.res = p[15:0];
      end
      4'd9: begin
        p = ua;
        for (int i = 0; i < s; i++) p = (p * 2) % 65536 + p / 32768;
        e.res = p[15:0];
      end
      4'd10: begin
        p = ua;
        for (int i = 0; i < s; i++) p = (p % 2) * 32768 + p / 2;
        e.res = p[15:0];
      end
      4'd11: e.res = vb;
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 16'h0000);
    e.neg  = e.res[15];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (op=%0d a=%h b=%h)", tag, obs, exp, op, a, b);
    end
  endtask

  task automatic check_comb(input string tag);
    exp_t e;
    e = model(op, a, b);
    chk({tag, ".res"}, 32'(result),    32'(e.res));
    chk({tag, ".hi"},  32'(result_hi), 32'(e.hi));
    chk({tag, ".ovf"}, 32'(ovf),       32'(e.ovf));
    chk({tag, ".z"},   32'(zero),      32'(e.zero));
    chk({tag, ".n"},   32'(neg),       32'(e.neg));
    chk({tag, ".dbz"}, 32'(dbz),       32'(e.dbz));
    chk({tag, ".ill"}, 32'(illegal),   32'(e.ill));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a, b, res, hi;
    logic        ovf, dbz;
  } dir_t;

  dir_t dir [] = '{
    '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b1, 1'b0},
    '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0, 1'b0},
    '{4'd4,  16'h0100, 16'h0100, 16'h0000, 16'h0001, 1'b1, 1'b0},
    '{4'd4,  16'hFFFE, 16'h0003, 16'hFFFA, 16'hFFFF, 1'b0, 1'b0},
    '{4'd5,  16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0},
    '{4'd5,  16'hFFF9, 16'h0000, 16'h0000, 16'hFFF9, 1'b0, 1'b1},
    '{4'd5,  16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 1'b0},
    '{4'd6,  16'h8001, 16'h0004, 16'h0010, 16'h0000, 1'b0, 1'b0},
    '{4'd7,  16'h8001, 16'h0004, 16'h0800, 16'h0000, 1'b0, 1'b0},
    '{4'd8,  16'h8001, 16'h0004, 16'hF800, 16'h0000, 1'b0, 1'b0},
    '{4'd9,  16'h8001, 16'h0004, 16'h0018, 16'h0000, 1'b0, 1'b0},
    '{4'd10, 16'h8001, 16'h0004, 16'h1800, 16'h0000, 1'b0, 1'b0},
    '{4'd6,  16'h8001, 16'h0010, 16'h8001, 16'h0000, 1'b0, 1'b0},
    '{4'd7,  16'h8001, 16'h0010, 16'h8001, 16'h0000, 1'b0, 1'b0},
    '{4'd8,  16'h8001, 16'h0010, 16'h8001, 16'h0000, 1'b0, 1'b0},
    '{4'd9,  16'h8001, 16'h0010, 16'h8001, 16'h0000, 1'b0, 1'b0},
    '{4'd10, 16'h8001, 16'h0010, 16'h8001, 16'h0000, 1'b0, 1'b0},
    '{4'd13, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b0, 1'b0}
  };

  initial begin
    exp_t       e;
    logic [3:0] exp_cc;

    // Reset held with capture enabled on a flag-producing op: cc must stay 0.
    rst_n = 1'b0; flag_en = 1'b1; op = 4'd0; a = 16'h7FFF; b = 16'h0001;
    #1 chk("cc_reset", 32'(cc), 32'h0);
    repeat (2) @(posedge clk);
    #1 chk("cc_reset_hold", 32'(cc), 32'h0);

    // Directed vectors with hand-computed results.
    foreach (dir[i]) begin
      @(negedge clk);
      op = dir[i].op; a = dir[i].a; b = dir[i].b;
      #1;
      chk("dir.res", 32'(result),    32'(dir[i].res));
      chk("dir.hi",  32'(result_hi), 32'(dir[i].hi));
      chk("dir.ovf", 32'(ovf),       32'(dir[i].ovf));
      chk("dir.dbz", 32'(dbz),       32'(dir[i].dbz));
      check_comb("dir");
    end

    // Condition-code register.
    @(negedge clk);
    rst_n = 1'b1; flag_en = 1'b1; op = 4'd1; a = 16'h1234; b = 16'h1234;
    @(posedge clk); #1 chk("cc_sub_zero", 32'(cc), 32'b0100);
    @(negedge clk);
    flag_en = 1'b0; op = 4'd0; a = 16'h7FFF; b = 16'h0001;
    @(posedge clk); #1 chk("cc_hold", 32'(cc), 32'b0100);
    @(negedge clk);
    flag_en = 1'b1;
    @(posedge clk); #1 chk("cc_add_ovf", 32'(cc), 32'b1010);
    #2 rst_n = 1'b0;
    #1 chk("cc_async_clr", 32'(cc), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cc = 4'b0000;

    // Random regression against the model, including cc tracking.
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      op = 4'($urandom_range(0, 15));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = 16'h0000;
      if ($urandom_range(0, 15) == 0) begin a = 16'h8000; b = 16'hFFFF; end
      flag_en = 1'($urandom);
      #1 check_comb("rnd");
      e = model(op, a, b);
      if (flag_en) exp_cc = {e.ovf, e.zero, e.neg, e.dbz};
      @(posedge clk);
      #1 chk("rnd.cc", 32'(cc), 32'(exp_cc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
